// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine: opcodes, FSM states, MIN helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Most negative two's-complement value of a given width, right-aligned in 64 bits.
  function automatic logic [63:0] min_val(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on magnitudes.
// o_acc/o_sh hold {product hi, product lo} or {remainder, quotient} after WIDTH steps.
module muldiv_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_sh,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_opnd;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;

  // Remainder stays below the divisor, so WIDTH+1 bits are enough for the trial subtract.
  assign w_mul_sum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_acc, r_sh[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_acc  <= '0;
      r_sh   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_acc  <= '0;
      r_sh   <= i_x;
      r_opnd <= i_y;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (i_is_div) begin
        if (!w_div_diff[WIDTH]) begin
          r_acc <= w_div_diff[WIDTH-1:0];
          r_sh  <= {r_sh[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_div_shift[WIDTH-1:0];
          r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= w_mul_sum[WIDTH:1];
        r_sh  <= {w_mul_sum[0], r_sh[WIDTH-1:1]};
      end
    end
  end

  assign o_acc  = r_acc;
  assign o_sh   = r_sh;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO and MTHI/MTLO writes.
// MULDIV_ACCUM_EN enables MADD/MADDU accumulation into {hi,lo}; otherwise they act as MULT/MULTU.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_dividend;
  logic             r_done;
  logic             r_dbz;
  logic             r_is_div;
  logic             r_dz;
  logic             r_rsvd;
  logic             r_neg_p;
  logic             r_neg_r;
`ifdef MULDIV_ACCUM_EN
  logic             r_accum;
`endif

  logic               w_sgn;
  logic               w_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_acc;
  logic [WIDTH-1:0]   w_sh;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_sgn   = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  assign w_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  muldiv_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .Clk      (Clk),
    .Clr      (Clr),
    .i_load   ((r_state == IDLE) && start),
    .i_step   (r_state == CALC),
    .i_is_div (r_is_div),
    .i_x      (w_div ? w_a_mag : w_b_mag),
    .i_y      (w_div ? w_b_mag : w_a_mag),
    .o_acc    (w_acc),
    .o_sh     (w_sh),
    .o_last   (w_last)
  );

  // Remainder follows the dividend sign; quotient and product follow sign(a)^sign(b).
  assign w_prod   = {w_acc, w_sh};
  assign w_prod_s = r_neg_p ? -w_prod : w_prod;
  assign w_quot   = r_neg_p ? -w_sh : w_sh;
  assign w_rem    = r_neg_r ? -w_acc : w_acc;
`ifdef MULDIV_ACCUM_EN
  assign w_mul_res = r_accum ? ({r_hi, r_lo} + w_prod_s) : w_prod_s;
`else
  assign w_mul_res = w_prod_s;
`endif

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state    <= IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dividend <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_rsvd     <= 1'b0;
      r_neg_p    <= 1'b0;
      r_neg_r    <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      r_accum    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_wr) r_hi <= wdata;
          if (lo_wr) r_lo <= wdata;
          if (start) begin
            r_state    <= CALC;
            r_dividend <= a;
            r_is_div   <= w_div;
            r_dz       <= w_div && (b == '0);
            r_rsvd     <= (op[2:1] == 2'b11);
            r_neg_p    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg & w_div;
`ifdef MULDIV_ACCUM_EN
            r_accum    <= (op == OP_MADD) || (op == OP_MADDU);
`endif
          end
        end
        CALC: begin
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          if (!r_rsvd) begin
            if (r_is_div && r_dz) begin
              r_hi  <= r_dividend;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end else begin
              {r_hi, r_lo} <= w_mul_res;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit (WIDTH=32): directed ops, HI/LO writes, Clr abort.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Clr, start, hi_wr, lo_wr;
  logic [2:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Clr(Clr), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int exp_done = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  exp_t m_e;
  always @(negedge Clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        m_e = sb.pop_front();
        chk({m_e.name, "_hi"}, hi, m_e.hi);
        chk({m_e.name, "_lo"}, lo, m_e.lo);
        chk({m_e.name, "_dbz"}, div_by_zero, m_e.dbz);
        chk({m_e.name, "_cycle"}, cyc, m_e.cyc);
        chk({m_e.name, "_busy"}, busy, 0);
      end
    end else if (div_by_zero) begin
      total++;
      bad++;
      $display("FAIL dbz_without_done: got div_by_zero=1 done=0 expected div_by_zero=0");
    end
  end

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez);
    exp_t e;
    e.name = nm; e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + W + 2;
    sb.push_back(e);
    exp_done++;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    op = 3'd2; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && n_done < exp_done; i++) @(negedge Clk);
    @(negedge Clk);
    if (n_done < exp_done) begin
      total++;
      bad++;
      $display("FAIL timeout: got done count %0d expected %0d", n_done, exp_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Clr = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op = 3'd0; a = '0; b = '0; wdata = '0;
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    Clr = 1'b0;
    @(negedge Clk);

    issue("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    chk("mult_busy_c1", busy, 1);
    wait_done();
    issue("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'h0000000E, 1'b0);
    wait_done();
    issue("div_neg_a", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done();
    issue("div_neg_b", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    wait_done();
    issue("div_zero", 3'd2, 32'h0000002A, 32'd0, 32'h0000002A, 32'hFFFFFFFF, 1'b1);
    wait_done();
    issue("divu_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    wait_done();
    issue("div_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    wait_done();
    issue("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done();
    issue("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0);
    wait_done();

    hi_wr = 1'b1; wdata = 32'h55;
    @(negedge Clk);
    hi_wr = 1'b0;
    chk("mthi_hi", hi, 32'h55);
    chk("mthi_lo", lo, 0);

    issue("multu_ign", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    repeat (4) @(negedge Clk);
    start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3; hi_wr = 1'b1; wdata = 32'hAA;
    @(negedge Clk);
    start = 1'b0; hi_wr = 1'b0;
    chk("busy_hi_kept", hi, 32'h55);
    wait_done();

    lo_wr = 1'b1; wdata = 32'h1234;
    issue("mtlo_start", 3'd3, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);
    lo_wr = 1'b0;
    chk("mtlo_same_cycle", lo, 32'h1234);
    wait_done();

    issue("reserved", 3'd6, 32'd3, 32'd3, 32'd1, 32'd7, 1'b0);
    wait_done();

    op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (50) @(negedge Clk);
    chk("abort_no_done", n_done, exp_done);

    hi_wr = 1'b1; wdata = 32'd0;
    @(negedge Clk);
    hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'hFFFFFFFF;
    @(negedge Clk);
    lo_wr = 1'b0;
`ifdef MULDIV_ACCUM_EN
    issue("maddu", 3'd5, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0);
    wait_done();
    issue("madd", 3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0);
    wait_done();
`else
    issue("maddu", 3'd5, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0);
    wait_done();
    issue("madd", 3'd4, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
